maze_cmd_seq: RTL
=================

// Module: maze_cmd_seq
// PURPOSE
//  Host-command sequencer for the navigation datapath. Accepts 16-bit commands from the
//  UART command wrapper, runs calibrate/heading/move directly, and hands the heading and
//  move controls to maze_solve for autonomous solve. Owns the strt_hdng/dsrd_hdng/strt_mv/
//  stp_* resource and grants it to host path or solver; emits one response byte per command.
// PARAMETERS
//  RESP_ACK   8'hA5  response byte on successful completion
//  RESP_NAK   8'hEE  response byte for an illegal opcode
//  HDNG_W     12     heading width
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst_n         in   1       asynchronous active-low reset
//  cmd           in   16      command word; [15:13] opcode, [11:0] operand
//  cmd_rdy       in   1       level, cmd valid until cleared
//  clr_cmd_rdy   out  1       1-cycle pulse: cmd accepted
//  strt_cal      out  1       1-cycle pulse: start gyro calibration
//  cal_done      in   1       calibration complete pulse
//  strt_hdng     out  1       1-cycle pulse to heading controller
//  dsrd_hdng     out  12      heading to heading controller
//  strt_mv       out  1       1-cycle pulse: start forward move
//  stp_lft       out  1       move stops at left opening
//  stp_rght      out  1       move stops at right opening
//  mv_cmplt      in   1       heading or move complete pulse (shared)
//  cmd_md        out  1       1 = host owns datapath; 0 = solver owns it
//  cmd0          out  1       solver affinity: 1 = left-hand, 0 = right-hand
//  sol_cmplt     in   1       maze solved (level, from magnet sensor)
//  slv_strt_hdng in   1       solver request, forwarded only when cmd_md=0
//  slv_dsrd_hdng in   12      solver heading, forwarded only when cmd_md=0
//  slv_strt_mv   in   1       solver move request, forwarded only when cmd_md=0
//  send_resp     out  1       1-cycle pulse: transmit resp
//  resp          out  8       response byte, valid with send_resp
// BEHAVIOUR
//  Reset: state IDLE; all pulses 0; cmd_md=1; cmd0=0; hdng_reg=12'h000; stp_lft=stp_rght=0;
//   resp=RESP_ACK.
//  Opcodes: 000 CAL; 001 HDNG (hdng_reg<=cmd[11:0]); 010 MOVE (stp_lft<=cmd[1],
//   stp_rght<=cmd[0]); 011 SOLVE (cmd0<=cmd[0]); 1xx illegal.
//  States: IDLE, EXEC, WAIT_CAL, WAIT_MV, WAIT_SOL, RESP.
//  IDLE: cmd_rdy=1 -> clr_cmd_rdy=1 same cycle, latch operand fields, -> EXEC.
//  EXEC (1 cycle): CAL: strt_cal=1 -> WAIT_CAL; HDNG: strt_hdng=1 -> WAIT_MV;
//   MOVE: strt_mv=1 -> WAIT_MV; SOLVE: -> WAIT_SOL; illegal: resp<=RESP_NAK -> RESP.
//   Start pulse therefore occurs exactly 1 cycle after clr_cmd_rdy.
//  WAIT_CAL: cal_done -> RESP.  WAIT_MV: mv_cmplt -> RESP.
//  WAIT_SOL: cmd_md=0 (registered, low from entry until exit); sol_cmplt -> RESP.
//  RESP (1 cycle): send_resp=1, resp driven; resp returns to RESP_ACK; -> IDLE; cmd_md=1.
//  Mux: cmd_md=0 -> strt_hdng/dsrd_hdng/strt_mv = slv_* (combinational pass-through);
//   stp_lft=cmd0, stp_rght=~cmd0. cmd_md=1 -> host values; slv_* ignored entirely.
//  cmd_rdy while busy: not cleared, no effect; accepted on first IDLE cycle after RESP.
//  Done pulse in EXEC cycle ignored (start not yet issued). sol_cmplt already 1 on SOLVE
//   entry: exits WAIT_SOL next cycle. mv_cmplt in WAIT_CAL/WAIT_SOL ignored.
//  No timeout; rst_n assertion mid-command aborts to reset values immediately.
// STRUCTURE
//  maze_pkg: opcode_t enum (OP_CAL, OP_HDNG, OP_MOVE, OP_SOLVE), seq_state_t,
//   HDNG_W. Response bytes stay parameters.
//  Single module; ownership mux is ~10 lines, no sub-module.
// TESTING
//  cmd=16'h0000, cmd_rdy=1 -> clr_cmd_rdy cyc0, strt_cal cyc1; cal_done -> send_resp, resp=8'hA5.
//  cmd=16'h23FF -> strt_hdng 1 cyc after clr, dsrd_hdng=12'h3FF held; mv_cmplt -> resp 8'hA5.
//  cmd=16'h4002 -> stp_lft=1, stp_rght=0, strt_mv pulse; second cmd_rdy mid-move not cleared.
//  cmd=16'h6001 -> cmd_md=0, cmd0=1, slv_dsrd_hdng=12'h7FF appears on dsrd_hdng; sol_cmplt
//   -> send_resp, cmd_md=1; host hdng_reg (12'h3FF) restored on dsrd_hdng.
//  cmd=16'hE000 -> no start pulses; send_resp with resp=8'hEE; next ACK command resp=8'hA5.
//  rst_n low during WAIT_MV -> async return: cmd_md=1, dsrd_hdng=12'h000, no send_resp.

Source files
------------

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types and widths for the maze command sequencer
package maze_pkg;

  localparam int HDNG_W = 12;

  // Opcode lives in cmd[15:13]; any value with the top bit set is illegal.
  typedef enum logic [2:0] {
    OP_CAL   = 3'b000,
    OP_HDNG  = 3'b001,
    OP_MOVE  = 3'b010,
    OP_SOLVE = 3'b011
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_CAL,
    S_WAIT_MV,
    S_WAIT_SOL,
    S_RESP
  } seq_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/maze_cmd_seq.sv
// rtl/maze_cmd_seq.sv - host command sequencer and heading/move ownership mux
module maze_cmd_seq
  import maze_pkg::*;
#(
  parameter logic [7:0] RESP_ACK = 8'hA5,
  parameter logic [7:0] RESP_NAK = 8'hEE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       cmd,
  input  logic              cmd_rdy,
  output logic              clr_cmd_rdy,
  output logic              strt_cal,
  input  logic              cal_done,
  output logic              strt_hdng,
  output logic [HDNG_W-1:0] dsrd_hdng,
  output logic              strt_mv,
  output logic              stp_lft,
  output logic              stp_rght,
  input  logic              mv_cmplt,
  output logic              cmd_md,
  output logic              cmd0,
  input  logic              sol_cmplt,
  input  logic              slv_strt_hdng,
  input  logic [HDNG_W-1:0] slv_dsrd_hdng,
  input  logic              slv_strt_mv,
  output logic              send_resp,
  output logic [7:0]        resp
);

  seq_state_t        state_q;
  logic [2:0]        op_q;
  logic [HDNG_W-1:0] hdng_q;
  logic              stp_lft_q;
  logic              stp_rght_q;
  logic              cmd0_q;
  logic              cmd_md_q;
  logic              strt_cal_q;
  logic              strt_hdng_q;
  logic              strt_mv_q;
  logic              send_resp_q;
  logic [7:0]        resp_q;
  logic              unused_cmd_bit;

  assign unused_cmd_bit = cmd[12];

  // Acknowledge in the same cycle the command is seen, so the wrapper drops cmd_rdy promptly.
  assign clr_cmd_rdy = (state_q == S_IDLE) && cmd_rdy;

  // Start pulses are set on acceptance so they land in the EXEC cycle, one after clr_cmd_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      hdng_q      <= '0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      cmd0_q      <= 1'b0;
      cmd_md_q    <= 1'b1;
      strt_cal_q  <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      send_resp_q <= 1'b0;
      resp_q      <= RESP_ACK;
    end else begin
      strt_cal_q  <= 1'b0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      send_resp_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_rdy) begin
            op_q    <= cmd[15:13];
            state_q <= S_EXEC;
            case (cmd[15:13])
              OP_CAL:  strt_cal_q <= 1'b1;
              OP_HDNG: begin
                hdng_q      <= cmd[HDNG_W-1:0];
                strt_hdng_q <= 1'b1;
              end
              OP_MOVE: begin
                stp_lft_q  <= cmd[1];
                stp_rght_q <= cmd[0];
                strt_mv_q  <= 1'b1;
              end
              OP_SOLVE: cmd0_q <= cmd[0];
              default: ;
            endcase
          end
        end
        S_EXEC: begin
          if (!op_is_legal(op_q)) begin
            resp_q      <= RESP_NAK;
            send_resp_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            case (op_q)
              OP_CAL:   state_q <= S_WAIT_CAL;
              OP_SOLVE: begin
                state_q  <= S_WAIT_SOL;
                cmd_md_q <= 1'b0;
              end
              default:  state_q <= S_WAIT_MV;
            endcase
          end
        end
        S_WAIT_CAL: begin
          if (cal_done) begin
            send_resp_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WAIT_MV: begin
          if (mv_cmplt) begin
            send_resp_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_WAIT_SOL: begin
          if (sol_cmplt) begin
            send_resp_q <= 1'b1;
            cmd_md_q    <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          resp_q   <= RESP_ACK;
          cmd_md_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // While the solver owns the datapath its requests pass straight through; stops follow affinity.
  always_comb begin
    strt_hdng = strt_hdng_q;
    dsrd_hdng = hdng_q;
    strt_mv   = strt_mv_q;
    stp_lft   = stp_lft_q;
    stp_rght  = stp_rght_q;
    if (!cmd_md_q) begin
      strt_hdng = slv_strt_hdng;
      dsrd_hdng = slv_dsrd_hdng;
      strt_mv   = slv_strt_mv;
      stp_lft   = cmd0_q;
      stp_rght  = ~cmd0_q;
    end
  end

  assign strt_cal  = strt_cal_q;
  assign cmd_md    = cmd_md_q;
  assign cmd0      = cmd0_q;
  assign send_resp = send_resp_q;
  assign resp      = resp_q;

endmodule
